// File: rtl/logs_period_meter_pkg.sv
// Shared logs_* constants: period-meter state encoding and synchronizer depth.
package logs_period_meter_pkg;

  localparam logic [1:0] LOGS_ST_IDLE    = 2'd0;
  localparam logic [1:0] LOGS_ST_MEASURE = 2'd1;
  localparam logic [1:0] LOGS_ST_STALL   = 2'd2;

  localparam int LOGS_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = LOGS_ST_IDLE,
    ST_MEASURE = LOGS_ST_MEASURE,
    ST_STALL   = LOGS_ST_STALL
  } pm_state_e;

endpackage

// File: rtl/logs_sync2.sv
// Two-flop synchronizer for a single-bit level; flops clear on async active-high reset.
module logs_sync2
  import logs_period_meter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [LOGS_SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LOGS_SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[LOGS_SYNC_STAGES-1];

endmodule

// File: rtl/logs_period_meter.sv
// Measures clocks between successive pulse_in events; sticky timeout after 2^WIDTH-1 idle clocks.
// Build option: define LOGS_PERIOD_METER_SYNC_EN to pass pulse_in through logs_sync2 first.
module logs_period_meter
  import logs_period_meter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic [1:0]       dbg_state_o
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic event_w;

`ifdef LOGS_PERIOD_METER_SYNC_EN
  logs_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pulse_in),
    .q_o   (event_w)
  );
`else
  assign event_w = pulse_in;
`endif

  pm_state_e        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // An event seen while cnt_q is saturated still measures: it wins over the timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (event_w) begin
          cnt_d   = CNT_ONE;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (event_w) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_STALL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STALL: begin
        if (event_w) begin
          timeout_d = 1'b0;
          cnt_d     = CNT_ONE;
          state_d   = ST_MEASURE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // period_valid is a one-clock strobe with no ready: a consumer must take period on that clock.
  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_logs_period_meter.sv
// Directed bench for logs_period_meter: WIDTH=8 and WIDTH=4 instances share clock and reset.
module tb_logs_period_meter;
  import logs_period_meter_pkg::*;

`ifdef LOGS_PERIOD_METER_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse8;
  logic       pulse4;
  logic [7:0] period8;
  logic       valid8;
  logic       timeout8;
  logic [1:0] st8;
  logic [3:0] period4;
  logic       valid4;
  logic       timeout4;
  logic [1:0] st4;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  logs_period_meter #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .pulse_in     (pulse8),
    .period       (period8),
    .period_valid (valid8),
    .timeout      (timeout8),
    .dbg_state_o  (st8)
  );

  logs_period_meter #(.WIDTH(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .pulse_in     (pulse4),
    .period       (period4),
    .period_valid (valid4),
    .timeout      (timeout4),
    .dbg_state_o  (st4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pulse8 = 1'b0;
    pulse4 = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++; if (period8 !== 8'd0) begin err_cnt++; $display("FAIL reset_period8: got %0d expected 0", period8); end
    vec_cnt++; if (valid8 !== 1'b0) begin err_cnt++; $display("FAIL reset_valid8: got %b expected 0", valid8); end
    vec_cnt++; if (timeout8 !== 1'b0) begin err_cnt++; $display("FAIL reset_timeout8: got %b expected 0", timeout8); end
    vec_cnt++; if (st8 !== LOGS_ST_IDLE) begin err_cnt++; $display("FAIL reset_state8: got %0d expected %0d", st8, LOGS_ST_IDLE); end
    vec_cnt++; if (period4 !== 4'd0) begin err_cnt++; $display("FAIL reset_period4: got %0d expected 0", period4); end
    vec_cnt++; if (valid4 !== 1'b0) begin err_cnt++; $display("FAIL reset_valid4: got %b expected 0", valid4); end
    vec_cnt++; if (timeout4 !== 1'b0) begin err_cnt++; $display("FAIL reset_timeout4: got %b expected 0", timeout4); end
    vec_cnt++; if (st4 !== LOGS_ST_IDLE) begin err_cnt++; $display("FAIL reset_state4: got %0d expected %0d", st4, LOGS_ST_IDLE); end
  endtask

  task automatic test_div5();
    logic exp_v;
    int   e;
    do_reset();
    for (int c = 0; c < 26 + S; c++) begin
      pulse8 = (c % 5 == 0) && (c <= 20);
      step();
      pulse8 = 1'b0;
      e = c - S;
      exp_v = (e >= 5) && (e % 5 == 0) && (e <= 20);
      vec_cnt++;
      if (valid8 !== exp_v) begin err_cnt++; $display("FAIL div5_valid c=%0d: got %b expected %b", c, valid8, exp_v); end
      if (exp_v) begin
        vec_cnt++;
        if (period8 !== 8'd5) begin err_cnt++; $display("FAIL div5_period c=%0d: got %0d expected 5", c, period8); end
      end
    end
  endtask

  task automatic test_continuous();
    logic exp_v;
    int   e;
    do_reset();
    for (int c = 0; c < 12 + S; c++) begin
      pulse8 = 1'b1;
      step();
      e = c - S;
      exp_v = (e >= 1);
      vec_cnt++;
      if (valid8 !== exp_v) begin err_cnt++; $display("FAIL cont_valid c=%0d: got %b expected %b", c, valid8, exp_v); end
      if (exp_v) begin
        vec_cnt++;
        if (period8 !== 8'd1) begin err_cnt++; $display("FAIL cont_period c=%0d: got %0d expected 1", c, period8); end
      end
    end
    pulse8 = 1'b0;
    vec_cnt++;
    if (timeout8 !== 1'b0) begin err_cnt++; $display("FAIL cont_timeout: got %b expected 0", timeout8); end
  endtask

  task automatic test_timeout();
    logic exp_v;
    logic exp_to;
    int   e;
    do_reset();
    for (int c = 0; c < 24 + S; c++) begin
      pulse4 = (c == 0) || (c == 20) || (c == 23);
      step();
      pulse4 = 1'b0;
      e = c - S;
      exp_to = (e >= 15) && (e < 20);
      exp_v  = (e == 23);
      vec_cnt++;
      if (timeout4 !== exp_to) begin err_cnt++; $display("FAIL to_timeout c=%0d: got %b expected %b", c, timeout4, exp_to); end
      vec_cnt++;
      if (valid4 !== exp_v) begin err_cnt++; $display("FAIL to_valid c=%0d: got %b expected %b", c, valid4, exp_v); end
      if (exp_v) begin
        vec_cnt++;
        if (period4 !== 4'd3) begin err_cnt++; $display("FAIL to_period c=%0d: got %0d expected 3", c, period4); end
      end
      if (e == 17) begin
        vec_cnt++;
        if (st4 !== LOGS_ST_STALL) begin err_cnt++; $display("FAIL to_state c=%0d: got %0d expected %0d", c, st4, LOGS_ST_STALL); end
      end
    end
  endtask

  task automatic test_boundary();
    logic exp_v;
    int   e;
    do_reset();
    for (int c = 0; c < 31 + S; c++) begin
      pulse4 = (c % 15 == 0) && (c <= 30);
      step();
      pulse4 = 1'b0;
      e = c - S;
      exp_v = (e == 15) || (e == 30);
      vec_cnt++;
      if (timeout4 !== 1'b0) begin err_cnt++; $display("FAIL bnd_timeout c=%0d: got %b expected 0", c, timeout4); end
      vec_cnt++;
      if (valid4 !== exp_v) begin err_cnt++; $display("FAIL bnd_valid c=%0d: got %b expected %b", c, valid4, exp_v); end
      if (exp_v) begin
        vec_cnt++;
        if (period4 !== 4'd15) begin err_cnt++; $display("FAIL bnd_period c=%0d: got %0d expected 15", c, period4); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp_v;
    int   e;
    do_reset();
    for (int c = 0; c < 7 + S; c++) begin
      pulse8 = (c == 0) || (c == 4);
      step();
      pulse8 = 1'b0;
      e = c - S;
      if (e == 4) begin
        vec_cnt++;
        if (period8 !== 8'd4 || valid8 !== 1'b1) begin
          err_cnt++; $display("FAIL mid_pre_period: got %0d/%b expected 4/1", period8, valid8);
        end
      end
    end
    vec_cnt++;
    if (st8 !== LOGS_ST_MEASURE) begin err_cnt++; $display("FAIL mid_pre_state: got %0d expected %0d", st8, LOGS_ST_MEASURE); end
    #2;
    reset = 1'b1;
    #1;
    vec_cnt++; if (period8 !== 8'd0) begin err_cnt++; $display("FAIL mid_rst_period: got %0d expected 0", period8); end
    vec_cnt++; if (valid8 !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_valid: got %b expected 0", valid8); end
    vec_cnt++; if (timeout8 !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_timeout: got %b expected 0", timeout8); end
    vec_cnt++; if (st8 !== LOGS_ST_IDLE) begin err_cnt++; $display("FAIL mid_rst_state: got %0d expected %0d", st8, LOGS_ST_IDLE); end
    step();
    reset = 1'b0;
    for (int c = 0; c < 13 + S; c++) begin
      pulse8 = (c == 2) || (c == 9);
      step();
      pulse8 = 1'b0;
      e = c - S;
      exp_v = (e == 9);
      vec_cnt++;
      if (valid8 !== exp_v) begin err_cnt++; $display("FAIL mid_post_valid c=%0d: got %b expected %b", c, valid8, exp_v); end
      if (exp_v) begin
        vec_cnt++;
        if (period8 !== 8'd7) begin err_cnt++; $display("FAIL mid_post_period c=%0d: got %0d expected 7", c, period8); end
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    pulse8 = 1'b0;
    pulse4 = 1'b0;
    test_reset();
    test_div5();
    test_continuous();
    test_timeout();
    test_boundary();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
